// File: rtl/div_check_pkg.sv
// Shared widths, FSM state encoding and helpers for the divider result checker.
package div_check_pkg;

  localparam int DIV_W  = 8;
  localparam int PROD_W = 2 * DIV_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] a,
                                                 input logic [PROD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/divider_result_recomposer_shift_add_step.sv
// One radix-2 shift-add iteration: add the shifted divisor when the quotient LSB is set.
module shift_add_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] d_sh,
  input  logic         q_lsb,
  output logic [W-1:0] acc_next
);

  // Worst-case sum stays below 2^W, so the carry-out is dropped.
  assign acc_next = q_lsb ? (acc + d_sh) : acc;

endmodule

// File: rtl/divider_result_recomposer.sv
// Rebuilds the dividend as q*d+r over WIDTH shift-add cycles and compares it to n_ref.
//
// state | meaning
// IDLE  | waiting for start; results hold their last values
// MUL   | one shift-add iteration per edge, WIDTH edges total
// FIN   | register n_out/mismatch/abs_err and pulse done
module divider_result_recomposer
  import div_check_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     q,
  input  logic [WIDTH-1:0]     d,
  input  logic [WIDTH-1:0]     r,
  input  logic [2*WIDTH-1:0]   n_ref,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   n_out,
  output logic                 mismatch,
  output logic [2*WIDTH-1:0]   abs_err
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [WIDTH-1:0] q_sh_q, q_sh_d;
  logic [PW-1:0]   d_sh_q, d_sh_d;
  logic [PW-1:0]   acc_q, acc_d, acc_next;
  logic [PW-1:0]   ref_q, ref_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   n_out_q, n_out_d;
  logic            mismatch_q, mismatch_d;
  logic [PW-1:0]   abs_err_q, abs_err_d;

  shift_add_step #(.W(PW)) u_step (
    .acc      (acc_q),
    .d_sh     (d_sh_q),
    .q_lsb    (q_sh_q[0]),
    .acc_next (acc_next)
  );

  always_comb begin
    state_d    = state_q;
    q_sh_d     = q_sh_q;
    d_sh_d     = d_sh_q;
    acc_d      = acc_q;
    ref_d      = ref_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    n_out_d    = n_out_q;
    mismatch_d = mismatch_q;
    abs_err_d  = abs_err_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          q_sh_d  = q;
          d_sh_d  = {{WIDTH{1'b0}}, d};
          ref_d   = n_ref;
          acc_d   = {{WIDTH{1'b0}}, r};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        // Fixed latency: no early exit once q_sh runs out of ones.
        acc_d  = acc_next;
        q_sh_d = q_sh_q >> 1;
        d_sh_d = d_sh_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIN;
      end
      FIN: begin
        n_out_d    = acc_q;
        mismatch_d = (acc_q != ref_q);
        abs_err_d  = abs_diff(acc_q, ref_q);
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      q_sh_q     <= '0;
      d_sh_q     <= '0;
      acc_q      <= '0;
      ref_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      n_out_q    <= '0;
      mismatch_q <= 1'b0;
      abs_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      q_sh_q     <= q_sh_d;
      d_sh_q     <= d_sh_d;
      acc_q      <= acc_d;
      ref_q      <= ref_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      n_out_q    <= n_out_d;
      mismatch_q <= mismatch_d;
      abs_err_q  <= abs_err_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign n_out    = n_out_q;
  assign mismatch = mismatch_q;
  assign abs_err  = abs_err_q;

endmodule

// File: tb/tb_divider_result_recomposer.sv
// Directed plus randomized bench for divider_result_recomposer against an arithmetic q*d+r model.
module tb_divider_result_recomposer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  q = '0, d = '0, r = '0;
  logic [15:0] n_ref = '0;
  logic        busy, done, mismatch;
  logic [15:0] n_out, abs_err;

  int n_checks = 0;
  int n_errors = 0;

  divider_result_recomposer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .q        (q),
    .d        (d),
    .r        (r),
    .n_ref    (n_ref),
    .busy     (busy),
    .done     (done),
    .n_out    (n_out),
    .mismatch (mismatch),
    .abs_err  (abs_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count edges until done is seen (sampled 1ns after each edge); bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
    end
  endtask

  task automatic check_result(input string tag, input int unsigned qi, input int unsigned di,
                              input int unsigned ri, input int unsigned ni);
    int unsigned exp_n, exp_err;
    exp_n   = qi * di + ri;
    exp_err = (exp_n >= ni) ? exp_n - ni : ni - exp_n;
    check({tag, "_done"}, done, 1);
    check({tag, "_n_out"}, n_out, exp_n);
    check({tag, "_mismatch"}, mismatch, (exp_n != ni) ? 1 : 0);
    check({tag, "_abs_err"}, abs_err, exp_err);
  endtask

  // Launch one operation; returns in the done cycle.
  task automatic do_op(input string tag, input logic [7:0] qi, input logic [7:0] di,
                       input logic [7:0] ri, input logic [15:0] ni, input bit hold_start);
    int edges;
    int busy_low;
    q = qi; d = di; r = ri; n_ref = ni; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_accept"}, busy, 1);
    if (!hold_start) begin
      start = 1'b0;
      q = 8'($urandom); d = 8'($urandom); r = 8'($urandom); n_ref = 16'($urandom);
    end
    edges = 0;
    busy_low = 0;
    while (edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (!busy) busy_low++;
      if (done) break;
    end
    check({tag, "_latency"}, edges, 9);
    check({tag, "_busy_held"}, busy_low, 0);
    check_result(tag, qi, di, ri, ni);
  endtask

  task automatic expect_idle(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int edges;
    int done_seen;
    logic [7:0]  rq, rd, rr;
    logic [15:0] rn;
    int unsigned prod;

    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_n_out", n_out, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_abs_err", abs_err, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    do_op("basic", 8'd15, 8'd13, 8'd5, 16'd200, 1'b0);
    expect_idle("basic_end");

    do_op("max", 8'd255, 8'd255, 8'd255, 16'd65280, 1'b0);
    expect_idle("max_end");

    do_op("d_zero", 8'hAA, 8'd0, 8'd7, 16'd10, 1'b0);
    expect_idle("d_zero_end");

    do_op("q_zero", 8'd0, 8'd77, 8'd200, 16'd200, 1'b0);
    expect_idle("q_zero_end");

    // Start held high: back-to-back acceptance on the done-cycle edge only.
    do_op("hold1", 8'd3, 8'd4, 8'd1, 16'd20, 1'b1);
    q = 8'd6; d = 8'd7; r = 8'd2; n_ref = 16'd44;
    @(posedge clk); #1;
    check("hold2_accept_busy", busy, 1);
    check("hold2_accept_done", done, 0);
    start = 1'b0;
    wait_done(edges);
    check("hold2_latency", edges, 9);
    check_result("hold2", 6, 7, 2, 44);
    expect_idle("hold2_end");

    // Asynchronous reset in the middle of MUL.
    q = 8'd9; d = 8'd9; r = 8'd0; n_ref = 16'd81; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_n_out", n_out, 0);
    check("arst_mismatch", mismatch, 0);
    check("arst_abs_err", abs_err, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("arst_no_done", done_seen, 0);
    do_op("after_rst", 8'd9, 8'd9, 8'd0, 16'd81, 1'b0);
    expect_idle("after_rst_end");

    // Randomized operations: exact and perturbed reference dividends.
    for (int k = 0; k < 24; k++) begin
      rq = 8'($urandom);
      rd = 8'($urandom);
      rr = 8'($urandom);
      prod = rq * rd + rr;
      case ($urandom_range(0, 2))
        0: rn = 16'(prod);
        1: rn = 16'(prod ^ (1 << $urandom_range(0, 15)));
        default: rn = 16'($urandom);
      endcase
      do_op("rand", rq, rd, rr, rn, 1'b0);
      if ($urandom_range(0, 1) == 1) expect_idle("rand_end");
      else @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
